// File: rtl/spi_tx_arbiter_pkg.sv
// Shared SPI package: arbiter FSM encoding, master command constant and the
// frame length legality helper.
package spi_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT_H = 3'd3,
        ST_WAIT_L = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [2:0] M_CMD_SINGLE_WRITE = 3'd0;

    localparam int TMO_W = 16;

    // A zero-length frame or one longer than the master's buffer is rejected.
    function automatic logic len_bad(input logic [7:0] n, input int max_n);
        return (n == 8'd0) || (int'(n) > max_n);
    endfunction

endpackage

// File: rtl/spi_tx_arbiter_if.sv
// Bundle of requester-side and SPI-master-side signals around the arbiter.
interface spi_tx_arbiter_if #(
    parameter int REQ_NUM      = 4,
    parameter int MAX_BYTE_NUM = 32
);
    // Handshake: a requester holds REQ_I[i] (with its BYTE_NUM/PDATA slice
    // stable) until it sees DONE_O[i] or ERR_O[i]; GNT_O[i] marks the frame in
    // flight. Towards the master, one M_START_O pulse launches a frame and the
    // master reports it with a BUSY high period whose falling edge ends it.
    logic [REQ_NUM-1:0]                REQ_I;
    logic [REQ_NUM*8-1:0]              BYTE_NUM_I;
    logic [REQ_NUM*MAX_BYTE_NUM*8-1:0] PDATA_I;
    logic [REQ_NUM-1:0]                GNT_O;
    logic [REQ_NUM-1:0]                DONE_O;
    logic [REQ_NUM-1:0]                ERR_O;
    logic [MAX_BYTE_NUM*8-1:0]         M_PDATA_O;
    logic [7:0]                        M_BYTE_NUM_O;
    logic [2:0]                        M_CMD_O;
    logic                              M_START_O;
    logic                              M_BUSY_I;

    modport slave (
        input  REQ_I, BYTE_NUM_I, PDATA_I, M_BUSY_I,
        output GNT_O, DONE_O, ERR_O, M_PDATA_O, M_BYTE_NUM_O, M_CMD_O, M_START_O
    );

    modport master (
        output REQ_I, BYTE_NUM_I, PDATA_I, M_BUSY_I,
        input  GNT_O, DONE_O, ERR_O, M_PDATA_O, M_BYTE_NUM_O, M_CMD_O, M_START_O
    );

endinterface

// File: rtl/spi_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant wins.
module rr_arbiter #(
    parameter int REQ_NUM = 4
) (
    input  logic [REQ_NUM-1:0]         req,
    input  logic [$clog2(REQ_NUM)-1:0] last_grant,
    output logic [REQ_NUM-1:0]         gnt
);
    localparam int IDX_W = $clog2(REQ_NUM);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= REQ_NUM; k++) begin
            idx = IDX_W'((int'(last_grant) + k) % REQ_NUM);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter that hands one requester's frame at a time to an SPI
// write master and reports completion, rejection or master timeout.
module spi_tx_arbiter
    import spi_tx_arbiter_pkg::*;
#(
    parameter int REQ_NUM      = 4,
    parameter int MAX_BYTE_NUM = 32,
    parameter int BUSY_TIMEOUT = 1023
) (
    input  logic            S_AXI_ACLK,
    input  logic            S_AXI_ARESETN,
    spi_tx_arbiter_if.slave bus,
    output state_t          fsm_state
);
    localparam int               IDX_W    = $clog2(REQ_NUM);
    localparam int               FRAME_W  = MAX_BYTE_NUM * 8;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

    state_t             state;
    logic [REQ_NUM-1:0] winner;
    logic [IDX_W-1:0]   win_idx;
    logic [REQ_NUM-1:0] sel;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   last_grant;
    logic [REQ_NUM-1:0] gnt_q;
    logic [REQ_NUM-1:0] done_q;
    logic [REQ_NUM-1:0] err_q;
    logic               start_q;
    logic [FRAME_W-1:0] pdata_q;
    logic [7:0]         byte_num_q;
    logic [7:0]         byte_num_sel;
    logic [TMO_W-1:0]   cnt;

    rr_arbiter #(.REQ_NUM(REQ_NUM)) u_rr (
        .req        (bus.REQ_I),
        .last_grant (last_grant),
        .gnt        (winner)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (winner[i]) win_idx = IDX_W'(i);
        end
    end

    assign byte_num_sel = bus.BYTE_NUM_I[sel_idx*8 +: 8];

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state      <= ST_IDLE;
            sel        <= '0;
            sel_idx    <= '0;
            last_grant <= IDX_W'(REQ_NUM - 1);
            gnt_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
            start_q    <= 1'b0;
            pdata_q    <= '0;
            byte_num_q <= '0;
            cnt        <= '0;
        end else begin
            done_q  <= '0;
            err_q   <= '0;
            start_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|bus.REQ_I) begin
                        sel     <= winner;
                        sel_idx <= win_idx;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    pdata_q    <= bus.PDATA_I[sel_idx*FRAME_W +: FRAME_W];
                    byte_num_q <= byte_num_sel;
                    if (len_bad(byte_num_sel, MAX_BYTE_NUM)) begin
                        // Rejected frames still rotate priority so a bad
                        // requester cannot starve the others.
                        err_q      <= sel;
                        last_grant <= sel_idx;
                        state      <= ST_IDLE;
                    end else begin
                        gnt_q   <= sel;
                        start_q <= 1'b1;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    cnt   <= '0;
                    state <= ST_WAIT_H;
                end
                ST_WAIT_H: begin
                    if (bus.M_BUSY_I) begin
                        state <= ST_WAIT_L;
                    end else if (cnt == TMO_LAST) begin
                        err_q      <= sel;
                        gnt_q      <= '0;
                        last_grant <= sel_idx;
                        state      <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_L: begin
                    if (!bus.M_BUSY_I) begin
                        done_q     <= sel;
                        gnt_q      <= '0;
                        last_grant <= sel_idx;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.GNT_O        = gnt_q;
    assign bus.DONE_O       = done_q;
    assign bus.ERR_O        = err_q;
    assign bus.M_PDATA_O    = pdata_q;
    assign bus.M_BYTE_NUM_O = byte_num_q;
    assign bus.M_CMD_O      = M_CMD_SINGLE_WRITE;
    assign bus.M_START_O    = start_q;
    assign fsm_state        = state;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed bench for spi_tx_arbiter: table of arbitration vectors plus
// hand-written latency, timeout, request-drop and mid-frame reset sequences.
module tb_spi_tx_arbiter;
    import spi_tx_arbiter_pkg::*;

    localparam int RN  = 4;
    localparam int MB  = 32;
    localparam int FW  = MB * 8;
    localparam int TMO = 16;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    state_t fsm_state;

    spi_tx_arbiter_if #(.REQ_NUM(RN), .MAX_BYTE_NUM(MB)) bus ();

    spi_tx_arbiter #(
        .REQ_NUM      (RN),
        .MAX_BYTE_NUM (MB),
        .BUSY_TIMEOUT (TMO)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .bus           (bus),
        .fsm_state     (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [7:0]  exp_q[$];
    logic [FW-1:0] frame [RN];
    logic [7:0]  bn [RN];

    // master model controls
    bit busy_en  = 1'b1;
    int busy_len = 20;

    // run_one results
    int          r_idx;
    bit          r_err;
    bit          r_start;
    bit          r_gnt_bad;
    bit          r_to;
    logic [RN-1:0] r_gnt;
    logic [RN-1:0] r_pulse;
    logic [7:0]  r_bytes;
    logic [FW-1:0] r_pdata;

    typedef struct {
        logic [RN-1:0] or_mask;
        int            bn_slot;
        logic [7:0]    bn_val;
        int            exp_idx;
        bit            exp_err;
    } vec_t;

    vec_t tbl [8];

    // ---------------- SPI master model ----------------
    initial begin : master_model
        int m_dly;
        int m_hold;
        m_dly  = 0;
        m_hold = 0;
        bus.M_BUSY_I = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.M_BUSY_I = 1'b0;
                m_dly  = 0;
                m_hold = 0;
            end else if (m_hold > 0) begin
                m_hold--;
                if (m_hold == 0) bus.M_BUSY_I = 1'b0;
            end else if (m_dly > 0) begin
                m_dly--;
                if (m_dly == 0) begin
                    bus.M_BUSY_I = 1'b1;
                    m_hold = busy_len;
                end
            end else if (bus.M_START_O && busy_en) begin
                m_dly = 3;
            end
        end
    end

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < RN; i++) begin
            bus.BYTE_NUM_I[i*8 +: 8] = bn[i];
            bus.PDATA_I[i*FW +: FW]  = frame[i];
        end
    endtask

    task automatic wait_state(input string name, input state_t s, input int budget);
        bit ok;
        ok = (fsm_state == s);
        for (int c = 0; c < budget && !ok; c++) begin
            @(posedge clk); #1;
            ok = (fsm_state == s);
        end
        if (!ok) check(name, 64'd0, 64'd1);
    endtask

    // Advance until a DONE/ERR pulse; the requester then drops that bit.
    task automatic run_one(input string name, input int budget);
        r_idx = -1; r_err = 1'b0; r_start = 1'b0; r_gnt_bad = 1'b0;
        r_to = 1'b1; r_gnt = '0; r_pulse = '0; r_bytes = '0; r_pdata = '0;
        for (int c = 0; c < budget && r_to; c++) begin
            @(posedge clk); #1;
            if (!$onehot0(bus.GNT_O)) r_gnt_bad = 1'b1;
            if (bus.M_START_O) begin
                r_start = 1'b1;
                r_gnt   = bus.GNT_O;
            end
            if (|(bus.DONE_O | bus.ERR_O)) begin
                r_pulse = bus.DONE_O | bus.ERR_O;
                r_err   = |bus.ERR_O;
                for (int i = 0; i < RN; i++) if (r_pulse[i]) r_idx = i;
                r_bytes = bus.M_BYTE_NUM_O;
                r_pdata = bus.M_PDATA_O;
                bus.REQ_I = bus.REQ_I & ~r_pulse;
                r_to = 1'b0;
            end
        end
        if (r_to) check({name, "_budget"}, 64'd1, 64'd0);
        else check({name, "_pulse_onehot"}, 64'($onehot(r_pulse)), 64'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        bit early;
        bit any_pulse;
        logic [7:0] e_idx;

        for (int i = 0; i < RN; i++)
            for (int j = 0; j < MB; j++)
                frame[i][j*8 +: 8] = 8'(i*40 + j + 1);
        bn[0] = 8'd26; bn[1] = 8'd1; bn[2] = 8'd5; bn[3] = 8'd32;
        bus.REQ_I = '0;
        apply_inputs();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt",   64'(bus.GNT_O), 64'd0);
        check("rst_done",  64'(bus.DONE_O | bus.ERR_O), 64'd0);
        check("rst_start", 64'(bus.M_START_O), 64'd0);
        check("rst_bytes", 64'(bus.M_BYTE_NUM_O), 64'd0);
        check("rst_pdata", 64'(bus.M_PDATA_O == '0), 64'd1);
        check("rst_cmd",   64'(bus.M_CMD_O), 64'd0);
        check("rst_state", 64'(fsm_state), 64'(ST_IDLE));
        rst_n = 1'b1;

        // contention and bad-length table; priority starts at index 0
        tbl[0] = '{4'b1011, -1, 8'd0,  0, 1'b0};
        tbl[1] = '{4'b0000, -1, 8'd0,  1, 1'b0};
        tbl[2] = '{4'b0001, -1, 8'd0,  3, 1'b0};
        tbl[3] = '{4'b0000, -1, 8'd0,  0, 1'b0};
        tbl[4] = '{4'b0100,  2, 8'd0,  2, 1'b1};
        tbl[5] = '{4'b0100,  2, 8'd33, 2, 1'b1};
        tbl[6] = '{4'b0110,  2, 8'd5,  1, 1'b0};
        tbl[7] = '{4'b0000, -1, 8'd0,  2, 1'b0};
        foreach (tbl[k]) exp_q.push_back(8'(tbl[k].exp_idx));

        busy_en  = 1'b1;
        busy_len = 20;
        for (int k = 0; k < 8; k++) begin
            if (tbl[k].bn_slot >= 0) begin
                bn[tbl[k].bn_slot] = tbl[k].bn_val;
                apply_inputs();
            end
            bus.REQ_I = bus.REQ_I | tbl[k].or_mask;
            run_one($sformatf("v%0d", k), 200);
            e_idx = exp_q.pop_front();
            check($sformatf("v%0d_idx", k), 64'(r_idx), 64'(e_idx));
            check($sformatf("v%0d_err", k), 64'(r_err), 64'(tbl[k].exp_err));
            check($sformatf("v%0d_start", k), 64'(r_start), 64'(!tbl[k].exp_err));
            check($sformatf("v%0d_gnt_onehot", k), 64'(r_gnt_bad), 64'd0);
            if (!tbl[k].exp_err) begin
                check($sformatf("v%0d_gnt", k), 64'(r_gnt), 64'(4'b0001 << tbl[k].exp_idx));
                check($sformatf("v%0d_bytes", k), 64'(r_bytes), 64'(bn[tbl[k].exp_idx]));
                check($sformatf("v%0d_pdata", k), 64'(r_pdata == frame[tbl[k].exp_idx]), 64'd1);
            end
        end

        // single request: START two cycles after REQ rises, one DONE pulse
        busy_len = 500;
        wait_state("a_idle", ST_IDLE, 20);
        bus.REQ_I = 4'b0001;
        @(posedge clk); #1;
        check("a_start_t1", 64'(bus.M_START_O), 64'd0);
        @(posedge clk); #1;
        check("a_start_t2", 64'(bus.M_START_O), 64'd1);
        check("a_bytes",    64'(bus.M_BYTE_NUM_O), 64'd26);
        check("a_gnt",      64'(bus.GNT_O), 64'b0001);
        run_one("a", 700);
        check("a_idx",        64'(r_idx), 64'd0);
        check("a_err",        64'(r_err), 64'd0);
        check("a_start_once", 64'(r_start), 64'd0);
        @(posedge clk); #1;
        check("a_done_once", 64'(bus.DONE_O), 64'd0);
        check("a_gnt_after", 64'(bus.GNT_O), 64'd0);

        // busy timeout: ERR 17 cycles after START
        busy_en  = 1'b0;
        busy_len = 20;
        wait_state("b_idle", ST_IDLE, 20);
        bus.REQ_I = 4'b0100;
        early = 1'b0;
        for (int c = 0; c < 10 && !bus.M_START_O; c++) begin
            @(posedge clk); #1;
        end
        check("b_start_seen", 64'(bus.M_START_O), 64'd1);
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (|bus.ERR_O) early = 1'b1;
        end
        check("b_no_early_err", 64'(early), 64'd0);
        @(posedge clk); #1;
        check("b_err",   64'(bus.ERR_O), 64'b0100);
        check("b_state", 64'(fsm_state), 64'(ST_IDLE));
        check("b_gnt",   64'(bus.GNT_O), 64'd0);
        bus.REQ_I = '0;
        busy_en   = 1'b1;

        // requester drops REQ during WAIT_L: DONE still reported
        wait_state("c_idle", ST_IDLE, 20);
        bus.REQ_I = 4'b0010;
        wait_state("c_wait_l", ST_WAIT_L, 50);
        bus.REQ_I[1] = 1'b0;
        run_one("c", 60);
        check("c_idx", 64'(r_idx), 64'd1);
        check("c_err", 64'(r_err), 64'd0);

        // reset in WAIT_L: outputs clear at once, no pulse, index 0 first after
        wait_state("d_idle", ST_IDLE, 20);
        bus.REQ_I = 4'b0100;
        wait_state("d_wait_l", ST_WAIT_L, 50);
        #2;
        rst_n = 1'b0;
        #1;
        check("d_gnt",   64'(bus.GNT_O), 64'd0);
        check("d_start", 64'(bus.M_START_O), 64'd0);
        check("d_bytes", 64'(bus.M_BYTE_NUM_O), 64'd0);
        check("d_pdata", 64'(bus.M_PDATA_O == '0), 64'd1);
        check("d_state", 64'(fsm_state), 64'(ST_IDLE));
        bus.REQ_I = '0;
        any_pulse = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (|(bus.DONE_O | bus.ERR_O)) any_pulse = 1'b1;
        end
        check("d_no_pulse", 64'(any_pulse), 64'd0);
        rst_n = 1'b1;
        bus.REQ_I = 4'b0101;
        run_one("d1", 200);
        check("d1_idx", 64'(r_idx), 64'd0);
        run_one("d2", 200);
        check("d2_idx", 64'(r_idx), 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
